addr_arbiter: RTL and testbench
===============================

# addr_arbiter

Registered, parametrised successor to the CPU's two-input address mux. It arbitrates between `NCH` address requesters, such as instruction fetch, operand fetch and a future DMA/debug port, using a req/grant/done handshake. It latches the winner's address and holds it stable on the shared memory address bus for a programmable number of cycles. It sits between the controller/PC/IR address sources and the memory address port.

## Interface
Parameters:
- `WIDTH`, default 5: address width in bits.
- `NCH`, default 2: number of requesting channels (2..8). Channel 0 is instruction fetch and channel 1 is operand.
- `HOLD`, default 1: cycles a granted address is held valid (1..16).

Ports:
- `clk`, input, 1: single clock, rising-edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `req`, input, `NCH`: per-channel request, level.
- `addr_in`, input, `NCH*WIDTH`: flattened addresses; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `gnt`, output, `NCH`: one-hot grant, registered.
- `addr_out`, output, `WIDTH`: latched address of the granted channel.
- `addr_valid`, output, 1: `addr_out` is driving a live access.
- `done`, output, `NCH`: one-hot, high in the final valid cycle of a grant.
- `busy`, output, 1: arbiter is in BUSY.

## Operation
- States:
  - IDLE: `gnt`=0, `addr_valid`=0, `busy`=0.
  - BUSY: `gnt` one-hot, `addr_valid`=1, `busy`=1.
- IDLE → BUSY when any `req` bit is high at a rising edge. On that edge:
  - the winner is selected;
  - its `addr_in` slice is copied into `addr_out`;
  - `gnt` is set to the winner;
  - the hold counter is loaded with `HOLD-1`.
- BUSY:
  - The counter decrements each edge.
  - `done[winner]` = `gnt[winner]` & (counter==0), decoded from registers only.
  - On the edge ending the counter==0 cycle, the block returns to IDLE.
- Winner selection, default: fixed priority, lowest index wins.
- `addr_in` and `req` changes during BUSY are ignored. `addr_out` stays frozen at the latched value.
- After a grant ends, `addr_out` retains its last value; it is not cleared. Only `addr_valid` drops.
- Requester rule: a requester drops `req` on the edge where it observes its `done`. A `req` still high in the following IDLE cycle is a new request.
- Counter width is 4 bits. Values of `HOLD` outside 1..16 are illegal; a simulation-time `$error` is raised.

## Timing
- Reset: every output is 0 on the edge after `rst` is sampled high. This covers `addr_out`=0, `gnt`=0, `done`=0, `addr_valid`=0 and `busy`=0. The counter is cleared and the round-robin pointer is set to 0.
- `rst` high mid-grant aborts the access on the next edge. No `done` is issued. The aborted requester must re-request.
- `rst` has priority over every other event.
- Grant latency: `req` high in cycle k gives `gnt`/`addr_out`/`addr_valid` in cycle k+1.
- Occupancy:
  - `addr_valid` is high for exactly `HOLD` consecutive cycles.
  - `done` is high in the last of those cycles.
  - At least one IDLE cycle follows every grant.
  - Maximum throughput is one access per `HOLD+1` cycles.
- `HOLD`=1: `addr_valid` and `done` are high in the same single cycle.
- Simultaneous requests: exactly one channel is granted. The others wait with `req` held and are not lost.

## Configuration
- `ADDR_ARB_ROUND_ROBIN_EN` defined:
  - Arbitration is round-robin.
  - Search starts at (last granted index + 1) mod `NCH`.
  - The pointer updates on each grant edge.
  - A continuously requesting channel waits at most `NCH-1` grants.
- Not defined:
  - Fixed priority with channel 0 highest.
  - No pointer register exists.
  - A channel held continuously can starve higher indices.

## Test plan
- Reset: drive `rst`=1 for 2 cycles with `req`=2'b11 → `gnt`=0, `addr_out`=5'b00000, `addr_valid`=0, `done`=0, `busy`=0 throughout, and on the first edge after release with `req` high the grant is issued.
- Single request, `HOLD`=2: `req`=01, ch0 addr 5'b10101 →
  - next cycle `gnt`=01 and `addr_out`=10101;
  - `addr_valid` is high for 2 cycles, with `done`=01 in the second;
  - then one IDLE cycle follows;
  - `addr_out` stays 10101 afterwards.
- Contention, ch0=5'b10101 and ch1=5'b11111, both `req` held, `HOLD`=1:
  - macro off → `addr_out` is 10101 on every grant;
  - macro on → it alternates 10101, 11111, 10101…
- Address change mid-grant: `HOLD`=3, and ch0 addr changes to 5'b00001 in the second BUSY cycle → `addr_out` stays 10101 through `done`.
- Reset during BUSY: `rst` pulsed in the first of 3 hold cycles → the next cycle has all outputs 0 and no `done` pulse.
- Channel count: `NCH`=3, ch2-only request with addr 5'b01110 → `gnt`=3'b100 and `addr_out`=01110 one cycle later.

Source files
------------

// File: rtl/addr_arbiter.sv
// addr_arbiter: a registered, parametrised address arbiter for the shared memory address bus.
// NCH requesters compete through a req/grant/done handshake. The winner's address is
// latched and held valid for HOLD cycles. At least one IDLE cycle follows every grant.
//
// Optional feature, selected by the macro ADDR_ARB_ROUND_ROBIN_EN:
//   defined   -> round-robin arbitration with a search-start pointer register
//   undefined -> fixed priority, channel 0 highest, no pointer register

module addr_arbiter #(
    parameter int WIDTH = 5,
    parameter int NCH   = 2,
    parameter int HOLD  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH-1:0]       req,
    input  logic [NCH*WIDTH-1:0] addr_in,
    output logic [NCH-1:0]       gnt,
    output logic [WIDTH-1:0]     addr_out,
    output logic                 addr_valid,
    output logic [NCH-1:0]       done,
    output logic                 busy
);

    localparam int         IDXW      = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [3:0] HOLD_LOAD = 4'(HOLD - 1);

    // An illegal configuration is reported while the design is elaborated
    if (HOLD < 1 || HOLD > 16) begin : g_hold_illegal
        $error("addr_arbiter: HOLD=%0d is outside the legal range 1..16", HOLD);
    end
    if (NCH < 2 || NCH > 8) begin : g_nch_illegal
        $error("addr_arbiter: NCH=%0d is outside the legal range 2..8", NCH);
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [IDXW-1:0]  winIdx;
    logic             anyReq;
    logic             cntZero;

    assign anyReq  = |req;
    assign cntZero = (cnt_q == 4'd0);

`ifdef ADDR_ARB_ROUND_ROBIN_EN
    logic [IDXW-1:0] ptr_q, ptr_d;
    logic            found;

    // Round-robin pick: first requester found when scanning upward from the pointer
    always_comb begin
        winIdx = '0;
        found  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NCH]) begin
                found  = 1'b1;
                winIdx = IDXW'((int'(ptr_q) + i) % NCH);
            end
        end
    end
`else
    // Fixed-priority pick: scanning downward means the lowest requesting index wins
    always_comb begin
        winIdx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                winIdx = IDXW'(i);
            end
        end
    end
`endif

    // State register: reset clears every register, which zeroes every output on the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            gnt_q   <= '0;
            addr_q  <= '0;
`ifdef ADDR_ARB_ROUND_ROBIN_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            addr_q  <= addr_d;
`ifdef ADDR_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Next-state logic: latch the winner from IDLE, then count the hold period down to zero
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        addr_d  = addr_q;
`ifdef ADDR_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (anyReq) begin
                    state_d = BUSY;
                    cnt_d   = HOLD_LOAD;
                    gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << winIdx;
                    addr_d  = addr_in[winIdx*WIDTH +: WIDTH];
`ifdef ADDR_ARB_ROUND_ROBIN_EN
                    ptr_d   = (int'(winIdx) == NCH - 1) ? '0 : winIdx + 1'b1;
`endif
                end
            end
            BUSY: begin
                if (cntZero) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode: all outputs come from registers only, and addr_out keeps its last value when idle
    always_comb begin
        gnt        = gnt_q;
        addr_out   = addr_q;
        addr_valid = (state_q == BUSY);
        busy       = (state_q == BUSY);
        done       = (state_q == BUSY && cntZero) ? gnt_q : '0;
    end

endmodule

// File: tb/tb_addr_arbiter.sv
// tb_addr_arbiter: directed checks of addr_arbiter using three instances.
//   A: NCH=3, HOLD=2  (reset, single request, channel 2, waiting requester)
//   B: NCH=2, HOLD=1  (contention, fixed priority vs round-robin)
//   C: NCH=2, HOLD=3  (reset mid-grant, address change mid-grant)

module tb_addr_arbiter;

    logic clk;
    logic rst;

    logic [2:0]  reqA;
    logic [14:0] addrA;
    logic [2:0]  gntA;
    logic [4:0]  addrOutA;
    logic        validA;
    logic [2:0]  doneA;
    logic        busyA;

    logic [1:0]  reqB;
    logic [9:0]  addrB;
    logic [1:0]  gntB;
    logic [4:0]  addrOutB;
    logic        validB;
    logic [1:0]  doneB;
    logic        busyB;

    logic [1:0]  reqC;
    logic [9:0]  addrC;
    logic [1:0]  gntC;
    logic [4:0]  addrOutC;
    logic        validC;
    logic [1:0]  doneC;
    logic        busyC;

    int testsRun;
    int testsFailed;

    logic [1:0] expG [3];
    logic [4:0] expA [3];
    logic [2:0] expGntA2;
    logic [4:0] expAddrA2;

    addr_arbiter #(.WIDTH(5), .NCH(3), .HOLD(2)) dutA (
        .clk(clk), .rst(rst), .req(reqA), .addr_in(addrA),
        .gnt(gntA), .addr_out(addrOutA), .addr_valid(validA), .done(doneA), .busy(busyA)
    );

    addr_arbiter #(.WIDTH(5), .NCH(2), .HOLD(1)) dutB (
        .clk(clk), .rst(rst), .req(reqB), .addr_in(addrB),
        .gnt(gntB), .addr_out(addrOutB), .addr_valid(validB), .done(doneB), .busy(busyB)
    );

    addr_arbiter #(.WIDTH(5), .NCH(2), .HOLD(3)) dutC (
        .clk(clk), .rst(rst), .req(reqC), .addr_in(addrC),
        .gnt(gntC), .addr_out(addrOutC), .addr_valid(validC), .done(doneC), .busy(busyC)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One comparison: count it, and on a mismatch count and report it
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkA(input string tag, input logic [2:0] g, input logic [4:0] a,
                          input logic v, input logic [2:0] d, input logic b);
        checkOutput({tag, ".A.gnt"},   32'(gntA),     32'(g));
        checkOutput({tag, ".A.addr"},  32'(addrOutA), 32'(a));
        checkOutput({tag, ".A.valid"}, 32'(validA),   32'(v));
        checkOutput({tag, ".A.done"},  32'(doneA),    32'(d));
        checkOutput({tag, ".A.busy"},  32'(busyA),    32'(b));
    endtask

    task automatic checkB(input string tag, input logic [1:0] g, input logic [4:0] a,
                          input logic v, input logic [1:0] d, input logic b);
        checkOutput({tag, ".B.gnt"},   32'(gntB),     32'(g));
        checkOutput({tag, ".B.addr"},  32'(addrOutB), 32'(a));
        checkOutput({tag, ".B.valid"}, 32'(validB),   32'(v));
        checkOutput({tag, ".B.done"},  32'(doneB),    32'(d));
        checkOutput({tag, ".B.busy"},  32'(busyB),    32'(b));
    endtask

    task automatic checkC(input string tag, input logic [1:0] g, input logic [4:0] a,
                          input logic v, input logic [1:0] d, input logic b);
        checkOutput({tag, ".C.gnt"},   32'(gntC),     32'(g));
        checkOutput({tag, ".C.addr"},  32'(addrOutC), 32'(a));
        checkOutput({tag, ".C.valid"}, 32'(validC),   32'(v));
        checkOutput({tag, ".C.done"},  32'(doneC),    32'(d));
        checkOutput({tag, ".C.busy"},  32'(busyC),    32'(b));
    endtask

    // Directed stimulus sequence with hand-computed expectations
    initial begin
        testsRun    = 0;
        testsFailed = 0;

`ifdef ADDR_ARB_ROUND_ROBIN_EN
        expG[0] = 2'b01; expA[0] = 5'b10101;
        expG[1] = 2'b10; expA[1] = 5'b11111;
        expG[2] = 2'b01; expA[2] = 5'b10101;
        expGntA2  = 3'b100;
        expAddrA2 = 5'b01110;
`else
        expG[0] = 2'b01; expA[0] = 5'b10101;
        expG[1] = 2'b01; expA[1] = 5'b10101;
        expG[2] = 2'b01; expA[2] = 5'b10101;
        expGntA2  = 3'b010;
        expAddrA2 = 5'b11111;
`endif

        rst   = 1'b1;
        reqA  = 3'b011;
        addrA = {5'b01110, 5'b11111, 5'b10101};
        reqB  = 2'b00;
        addrB = {5'b11111, 5'b10101};
        reqC  = 2'b00;
        addrC = {5'b00000, 5'b10101};

        // Reset held for two cycles with requests pending
        tick();
        checkA("rst1", 3'b000, 5'b00000, 1'b0, 3'b000, 1'b0);
        checkB("rst1", 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0);
        checkC("rst1", 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0);
        tick();
        checkA("rst2", 3'b000, 5'b00000, 1'b0, 3'b000, 1'b0);

        // First edge after release grants channel 0, held for two cycles
        rst = 1'b0;
        tick();
        checkA("grant0", 3'b001, 5'b10101, 1'b1, 3'b000, 1'b1);
        reqA = 3'b000;
        tick();
        checkA("hold0", 3'b001, 5'b10101, 1'b1, 3'b001, 1'b1);
        tick();
        checkA("idle0", 3'b000, 5'b10101, 1'b0, 3'b000, 1'b0);

        // Channel 2 alone
        reqA = 3'b100;
        tick();
        checkA("grant2", 3'b100, 5'b01110, 1'b1, 3'b000, 1'b1);
        reqA = 3'b000;
        tick();
        checkA("hold2", 3'b100, 5'b01110, 1'b1, 3'b100, 1'b1);
        tick();
        checkA("idle2", 3'b000, 5'b01110, 0, 3'b000, 1'b0);

        // Channels 1 and 2 held together: neither request is lost
        reqA = 3'b110;
        tick();
        checkA("pairG1", 3'b010, 5'b11111, 1'b1, 3'b000, 1'b1);
        tick();
        checkA("pairD1", 3'b010, 5'b11111, 1'b1, 3'b010, 1'b1);
        tick();
        checkA("pairI1", 3'b000, 5'b11111, 1'b0, 3'b000, 1'b0);
        tick();
        checkA("pairG2", expGntA2, expAddrA2, 1'b1, 3'b000, 1'b1);
        reqA = 3'b000;
        tick();
        checkA("pairD2", expGntA2, expAddrA2, 1'b1, expGntA2, 1'b1);
        tick();
        checkA("pairI2", 3'b000, expAddrA2, 1'b0, 3'b000, 1'b0);

        // Reset in the first of three hold cycles aborts with no done
        reqC = 2'b01;
        tick();
        checkC("abortG", 2'b01, 5'b10101, 1'b1, 2'b00, 1'b1);
        rst  = 1'b1;
        reqC = 2'b00;
        tick();
        checkC("abortR", 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0);
        checkA("abortR", 3'b000, 5'b00000, 1'b0, 3'b000, 1'b0);
        rst = 1'b0;
        tick();
        checkC("abortN", 2'b00, 5'b00000, 1'b0, 2'b00, 1'b0);

        // Address change during the grant is ignored
        reqC = 2'b01;
        tick();
        checkC("frzG", 2'b01, 5'b10101, 1'b1, 2'b00, 1'b1);
        addrC = {5'b00000, 5'b00001};
        reqC  = 2'b00;
        tick();
        checkC("frz1", 2'b01, 5'b10101, 1'b1, 2'b00, 1'b1);
        tick();
        checkC("frzD", 2'b01, 5'b10101, 1'b1, 2'b01, 1'b1);
        tick();
        checkC("frzI", 2'b00, 5'b10101, 1'b0, 2'b00, 1'b0);

        // Contention with HOLD=1: valid and done share the single grant cycle
        reqB = 2'b11;
        for (int g = 0; g < 3; g++) begin
            tick();
            checkB($sformatf("contG%0d", g), expG[g], expA[g], 1'b1, expG[g], 1'b1);
            tick();
            checkB($sformatf("contI%0d", g), 2'b00, expA[g], 1'b0, 2'b00, 1'b0);
        end
        reqB = 2'b00;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
